// File: rtl/layer_conf_loader.sv
// -----------------------------------------------------------------------------
// layer_conf_loader
//
// Receives 4-word layer descriptors over a valid/ready instruction stream,
// holds the descriptor in shadow registers, and commits it to the active
// configuration outputs when the PE array is idle or finishing its layer.
// Commit produces a one-cycle layer_start pulse and sets busy. One
// descriptor of prefetch is possible while a layer is running.
//
// Descriptor layout:
//   W0: [31:28] opcode (4'hA), [4] bit_mode, [3] kernel_mode, [2:0] wt_mode
//   W1: [15:0] in_ch,  [31:16] out_ch
//   W2: [15:0] fm_w,   [31:16] fm_h
//   W3: wt_base
//
// Optional macro LAYER_CONF_LOADER_CHECK_EN adds a sticky cfg_err flag for
// illegal descriptors and unknown opcodes. Without it, cfg_err is tied to 0.
// -----------------------------------------------------------------------------
module layer_conf_loader #(
    parameter int CONF_INS_WIDTH = 32,
    parameter int CH_WIDTH       = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CONF_INS_WIDTH-1:0] ins_data,
    input  logic                      ins_valid,
    output logic                      ins_ready,
    input  logic                      soft_clr,
    input  logic                      layer_done,
    output logic                      layer_start,
    output logic                      busy,
    output logic                      kernel_mode,
    output logic                      bit_mode,
    output logic [2:0]                wt_mode,
    output logic [CH_WIDTH-1:0]       in_ch,
    output logic [CH_WIDTH-1:0]       out_ch,
    output logic [CH_WIDTH-1:0]       fm_w,
    output logic [CH_WIDTH-1:0]       fm_h,
    output logic [31:0]               wt_base,
    output logic [CNT_WIDTH-1:0]      layer_cnt,
    output logic                      cfg_err
);

    localparam logic [3:0] OPC_LAYER = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [1:0]  wcnt, wcnt_next;

    // Shadow (prefetch) copy of the descriptor
    logic                sh_kernel_mode;
    logic                sh_bit_mode;
    logic [2:0]          sh_wt_mode;
    logic [CH_WIDTH-1:0] sh_in_ch;
    logic [CH_WIDTH-1:0] sh_out_ch;
    logic [CH_WIDTH-1:0] sh_fm_w;
    logic [CH_WIDTH-1:0] sh_fm_h;
    logic [31:0]         sh_wt_base;

    logic       xfer;
    logic       commit;
    logic [3:0] opcode;
    logic       w0_ok;

    assign opcode = ins_data[31:28];
    assign w0_ok  = (opcode == OPC_LAYER);

    // Ready is low while reset is held, while a descriptor waits in PEND,
    // and in any cycle where soft_clr is aborting the load.
    assign ins_ready = rst_n && (state != PEND) && !soft_clr;
    assign xfer      = ins_valid && ins_ready;

    // Commit when the array is idle, or is finishing its layer this cycle.
    assign commit = (state == PEND) && !soft_clr && (!busy || layer_done);

    // State and word-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // Next-state logic; soft_clr overrides every other transition
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        wcnt_next  = wcnt;
        if (soft_clr) begin
            state_next = IDLE;
            wcnt_next  = 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer && w0_ok) begin
                        state_next = LOAD;
                        wcnt_next  = 2'd1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (wcnt == 2'd3) begin
                            state_next = PEND;
                            wcnt_next  = 2'd0;
                        end else begin
                            wcnt_next = wcnt + 2'd1;
                        end
                    end
                end
                PEND: begin
                    if (commit) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    wcnt_next  = 2'd0;
                end
            endcase
        end
    end

    // Shadow capture: W0 in IDLE, W1..W3 in LOAD; soft_clr wipes the copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are a handful of flops, not a memory array, so
            // resetting them is cheap and makes post-reset state deterministic.
            sh_kernel_mode <= 1'b0;
            sh_bit_mode    <= 1'b0;
            sh_wt_mode     <= 3'd0;
            sh_in_ch       <= '0;
            sh_out_ch      <= '0;
            sh_fm_w        <= '0;
            sh_fm_h        <= '0;
            sh_wt_base     <= 32'd0;
        end else if (soft_clr) begin
            sh_kernel_mode <= 1'b0;
            sh_bit_mode    <= 1'b0;
            sh_wt_mode     <= 3'd0;
            sh_in_ch       <= '0;
            sh_out_ch      <= '0;
            sh_fm_w        <= '0;
            sh_fm_h        <= '0;
            sh_wt_base     <= 32'd0;
        end else if (xfer) begin
            if (state == IDLE && w0_ok) begin
                sh_bit_mode    <= ins_data[4];
                sh_kernel_mode <= ins_data[3];
                sh_wt_mode     <= ins_data[2:0];
            end else if (state == LOAD) begin
                unique case (wcnt)
                    2'd1: begin
                        sh_in_ch  <= ins_data[CH_WIDTH-1:0];
                        sh_out_ch <= ins_data[16+CH_WIDTH-1:16];
                    end
                    2'd2: begin
                        sh_fm_w <= ins_data[CH_WIDTH-1:0];
                        sh_fm_h <= ins_data[16+CH_WIDTH-1:16];
                    end
                    2'd3: begin
                        sh_wt_base <= ins_data[31:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Active configuration: updated only on commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kernel_mode <= 1'b0;
            bit_mode    <= 1'b0;
            wt_mode     <= 3'd0;
            in_ch       <= '0;
            out_ch      <= '0;
            fm_w        <= '0;
            fm_h        <= '0;
            wt_base     <= 32'd0;
        end else if (commit) begin
            kernel_mode <= sh_kernel_mode;
            bit_mode    <= sh_bit_mode;
            wt_mode     <= sh_wt_mode;
            in_ch       <= sh_in_ch;
            out_ch      <= sh_out_ch;
            fm_w        <= sh_fm_w;
            fm_h        <= sh_fm_h;
            wt_base     <= sh_wt_base;
        end
    end

    // Start pulse, busy tracking and committed-layer counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_start <= 1'b0;
            busy        <= 1'b0;
            layer_cnt   <= '0;
        end else begin
            layer_start <= commit;
            if (commit) begin
                busy      <= 1'b1;
                layer_cnt <= layer_cnt + 1'b1;
            end else if (layer_done) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef LAYER_CONF_LOADER_CHECK_EN
    logic cfg_err_q;
    logic bad_desc;
    logic bad_opcode;

    // E mode (4) only exists for 3x3 kernels; zero channel counts are illegal.
    assign bad_desc = (sh_wt_mode > 3'd4)
                   || (sh_in_ch == '0) || (sh_out_ch == '0)
                   || (sh_kernel_mode && (sh_wt_mode == 3'd4));
    assign bad_opcode = xfer && (state == IDLE) && !w0_ok;

    // Sticky error flag; the commit itself still proceeds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else if ((commit && bad_desc) || bad_opcode) begin
            cfg_err_q <= 1'b1;
        end
    end

    assign cfg_err = cfg_err_q;
`else
    assign cfg_err = 1'b0;
`endif

endmodule
